// File: rtl/nibble_feeder_if.sv
// nibble_feeder_if: producer handshake and accumulator-side signals of nibble_feeder.
// The producer/consumer side uses the master modport; the feeder itself uses slave.
interface nibble_feeder_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [3:0]    InData;
    logic          InValid;
    logic          InReady;
    logic [3:0]    Data;
    logic          DataValid;
    logic          FrameDone;
    logic [LW-1:0] Level;

    modport master (
        output InData,
        output InValid,
        input  InReady,
        input  Data,
        input  DataValid,
        input  FrameDone,
        input  Level
    );

    modport slave (
        input  InData,
        input  InValid,
        output InReady,
        output Data,
        output DataValid,
        output FrameDone,
        output Level
    );
endinterface

// File: rtl/nibble_feeder.sv
// nibble_feeder: buffers 4-bit producer samples in a DEPTH-entry FIFO and issues
// one sample per cycle to a downstream accumulator, grouped in frames of FRAME_LEN
// samples with a one-cycle DONE gap (FrameDone pulse) after each frame.
// Optional build macro NIBBLE_FEEDER_HOLD_EN adds a Hold input that stalls issuing.
module nibble_feeder #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
`ifdef NIBBLE_FEEDER_HOLD_EN
    input  logic Hold,
`endif
    nibble_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [7:0]    FL = 8'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    cnt;
    logic [7:0]    cnt_inc;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          hold_now;
    logic          push;
    logic          pop;
    logic [3:0]    data_q;
    logic          valid_q;
    logic          done_q;

`ifdef NIBBLE_FEEDER_HOLD_EN
    assign hold_now = Hold;
`else
    assign hold_now = 1'b0;
`endif

    assign full    = (level == LEVEL_FULL);
    assign empty   = (level == '0);
    assign push    = bus.InValid && !full;
    // Pop decision uses pre-edge occupancy, so a push into an empty FIFO is not
    // issued until the following edge.
    assign pop     = ((state == IDLE) || (state == RUN)) && !empty && !hold_now;
    assign cnt_inc = cnt + 8'd1;

    assign bus.InReady   = !full;
    assign bus.Level     = level;
    assign bus.Data      = data_q;
    assign bus.DataValid = valid_q;
    assign bus.FrameDone = done_q;

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.InData;
        end
    end

    // Circular pointers and occupancy tracking.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Frame FSM with registered Data/DataValid/FrameDone outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state)
                IDLE, RUN: begin
                    if (pop) begin
                        data_q  <= mem[rd_ptr];
                        valid_q <= 1'b1;
                        // IDLE enters with cnt=0, so both states share the
                        // increment; FRAME_LEN=1 goes straight to DONE.
                        if (cnt_inc == FL) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            state <= RUN;
                            cnt   <= cnt_inc;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    cnt    <= '0;
                    state  <= empty ? IDLE : RUN;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_feeder.sv
// tb_nibble_feeder: directed checks of nibble_feeder with hand-computed expectations.
// DUT A: FRAME_LEN=8, DUT B: FRAME_LEN=4, DUT C: FRAME_LEN=1; all DEPTH=4.
module tb_nibble_feeder;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic hold_a = 1'b0;
    logic [3:0] regsum;
    int n_checks = 0;
    int n_pass = 0;

    nibble_feeder_if #(.DEPTH(4)) bus_a ();
    nibble_feeder_if #(.DEPTH(4)) bus_b ();
    nibble_feeder_if #(.DEPTH(4)) bus_c ();

    nibble_feeder #(.DEPTH(4), .FRAME_LEN(8)) dut_a (
        .Clock(Clock),
        .Reset(Reset),
`ifdef NIBBLE_FEEDER_HOLD_EN
        .Hold(hold_a),
`endif
        .bus(bus_a.slave)
    );

    nibble_feeder #(.DEPTH(4), .FRAME_LEN(4)) dut_b (
        .Clock(Clock),
        .Reset(Reset),
`ifdef NIBBLE_FEEDER_HOLD_EN
        .Hold(1'b0),
`endif
        .bus(bus_b.slave)
    );

    nibble_feeder #(.DEPTH(4), .FRAME_LEN(1)) dut_c (
        .Clock(Clock),
        .Reset(Reset),
`ifdef NIBBLE_FEEDER_HOLD_EN
        .Hold(1'b0),
`endif
        .bus(bus_c.slave)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    // Downstream accumulator on DUT B: RegSum <= RegSum + Data.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) regsum <= '0;
        else        regsum <= regsum + bus_b.Data;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        bus_a.InValid = 1'b0; bus_a.InData = '0;
        bus_b.InValid = 1'b0; bus_b.InData = '0;
        bus_c.InValid = 1'b0; bus_c.InData = '0;
        hold_a = 1'b0;
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v_b [12];
        int fd_b [12];
        int lvl_c [10];
        int rdy_c [10];
        int pushes, good, fds, valids, fd_at, peak;

        // ---- reset state ----
        do_reset();
        check("rst_level", bus_a.Level, 0);
        check("rst_ready", bus_a.InReady, 1);
        check("rst_data", bus_a.Data, 0);
        check("rst_valid", bus_a.DataValid, 0);
        check("rst_done", bus_a.FrameDone, 0);

        // ---- 1: push 3,5,7 on DUT A ----
        bus_a.InValid = 1'b1; bus_a.InData = 4'd3;
        step();
        check("t1_lat_valid", bus_a.DataValid, 0);
        bus_a.InData = 4'd5;
        step();
        check("t1_d0", bus_a.Data, 3);
        check("t1_v0", bus_a.DataValid, 1);
        bus_a.InData = 4'd7;
        step();
        check("t1_d1", bus_a.Data, 5);
        bus_a.InValid = 1'b0;
        step();
        check("t1_d2", bus_a.Data, 7);
        check("t1_v2", bus_a.DataValid, 1);
        step();
        check("t1_idle_data", bus_a.Data, 0);
        check("t1_idle_valid", bus_a.DataValid, 0);
        check("t1_level", bus_a.Level, 0);
        fds = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_a.FrameDone) fds++;
            step();
        end
        check("t1_no_done", fds, 0);

        // ---- 2: FRAME_LEN=4, push 1 for 8 cycles on DUT B ----
        do_reset();
        v_b  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
        fd_b = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            bus_b.InValid = (i < 8);
            bus_b.InData  = 4'd1;
            step();
            check($sformatf("t2_valid%0d", i), bus_b.DataValid, v_b[i]);
            check($sformatf("t2_data%0d", i), bus_b.Data, v_b[i]);
            check($sformatf("t2_done%0d", i), bus_b.FrameDone, fd_b[i]);
            if (i == 5)  check("t2_regsum4", regsum, 4);
            if (i == 10) check("t2_regsum8", regsum, 8);
        end

        // ---- 3: fill DEPTH=4 on DUT C (FRAME_LEN=1, one pop per 2 cycles) ----
        do_reset();
        lvl_c = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3};
        rdy_c = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1};
        pushes = 0; good = 0; fds = 0; valids = 0; peak = 0;
        bus_c.InValid = 1'b1; bus_c.InData = 4'd9;
        for (int i = 0; i < 10; i++) begin
            if (bus_c.InReady) pushes++;
            step();
            check($sformatf("t3_level%0d", i), bus_c.Level, lvl_c[i]);
            check($sformatf("t3_ready%0d", i), bus_c.InReady, rdy_c[i]);
            if (int'(bus_c.Level) > peak) peak = int'(bus_c.Level);
            if (bus_c.DataValid) valids++;
            if (bus_c.DataValid && bus_c.Data == 4'd9) good++;
            if (bus_c.FrameDone) fds++;
        end
        check("t3_pushes", pushes, 8);
        check("t3_pops", valids, 5);
        check("t3_peak", peak, 4);
        bus_c.InValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_c.DataValid && bus_c.Data == 4'd9) good++;
            if (bus_c.FrameDone) fds++;
        end
        check("t3_issued", good, 8);
        check("t3_frames", fds, 8);
        check("t3_drained", bus_c.Level, 0);

        // ---- 4: mid-frame reset on DUT A ----
        do_reset();
        bus_a.InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_a.InData = 4'(i + 1);
            step();
        end
        check("t4_issue4", bus_a.Data, 4);
        Reset = 1'b0;
        #1;
        check("t4_rst_data", bus_a.Data, 0);
        check("t4_rst_valid", bus_a.DataValid, 0);
        check("t4_rst_level", bus_a.Level, 0);
        check("t4_rst_done", bus_a.FrameDone, 0);
        step();
        Reset = 1'b1;
        fds = 0; valids = 0; fd_at = -1;
        for (int i = 0; i < 14; i++) begin
            bus_a.InValid = (i < 8);
            bus_a.InData  = 4'd2;
            step();
            if (bus_a.DataValid) valids++;
            if (bus_a.FrameDone) begin
                fds++;
                fd_at = i;
            end
        end
        check("t4_issues", valids, 8);
        check("t4_frames", fds, 1);
        check("t4_done_at", fd_at, 9);

        // ---- 5: underflow gap on DUT B ----
        do_reset();
        v_b  = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        fd_b = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            bus_b.InValid = (i < 2) || (i == 5) || (i == 6);
            bus_b.InData  = 4'(i + 2);
            step();
            check($sformatf("t5_valid%0d", i), bus_b.DataValid, v_b[i]);
            check($sformatf("t5_done%0d", i), bus_b.FrameDone, fd_b[i]);
        end

`ifdef NIBBLE_FEEDER_HOLD_EN
        // ---- 6: Hold on DUT A ----
        do_reset();
        hold_a = 1'b1;
        bus_a.InValid = 1'b1; bus_a.InData = 4'd2;
        step();
        check("t6_hold_v0", bus_a.DataValid, 0);
        bus_a.InData = 4'd4;
        step();
        check("t6_hold_v1", bus_a.DataValid, 0);
        bus_a.InValid = 1'b0;
        step();
        check("t6_hold_v2", bus_a.DataValid, 0);
        check("t6_hold_level", bus_a.Level, 2);
        hold_a = 1'b0;
        step();
        check("t6_d0", bus_a.Data, 2);
        check("t6_v0", bus_a.DataValid, 1);
        step();
        check("t6_d1", bus_a.Data, 4);
        check("t6_v1", bus_a.DataValid, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
